reg_scoreboard: RTL and testbench

Issue-side scoreboard for the 32×32 register file in ID. It tracks in-flight writes per architectural register, from issue in ID until the matching writeback retires. It raises a combinational stall when the instruction in ID reads a register with a pending write, or when a destination's pending counter would overflow. It arbitrates register-file read access against outstanding writebacks; there is no forwarding, so a value is readable only after its write edge.

---
 rtl/reg_scoreboard_pkg.sv | 20 ++
 rtl/reg_scoreboard_sb_counter.sv | 45 ++++
 rtl/reg_scoreboard.sv | 110 +++++++++++
 tb/tb_reg_scoreboard.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/reg_scoreboard_pkg.sv
// Shared constants and types for the ID-stage register scoreboard.
package reg_scoreboard_pkg;

    localparam int REG_ADDR_W  = 5;
    localparam int SB_NUM_REGS = 32;
    localparam int SB_CNT_W    = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic      valid;
        reg_addr_t rs1;
        logic      use_rs1;
        reg_addr_t rs2;
        logic      use_rs2;
        reg_addr_t rd;
        logic      we;
    } issue_req_t;

endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// One pending-write counter: counts issued writes up, retired writebacks down,
// saturating at both ends and cleared by flush.
module sb_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W
)
(
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    input  logic             dec,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             at_max
);

    logic [CNT_W-1:0] count_r;
    logic             nonzero_s;
    logic             at_max_s;

    assign nonzero_s = (count_r != {CNT_W{1'b0}});
    assign at_max_s  = (count_r == {CNT_W{1'b1}});

    // Counter state: flush wins over traffic; simultaneous inc and dec cancel.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            count_r <= {CNT_W{1'b0}};
        end else if (inc && !dec && !at_max_s) begin
            count_r <= count_r + CNT_W'(1);
        end else if (dec && !inc && nonzero_s) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign count   = count_r;
    assign nonzero = nonzero_s;
    assign at_max  = at_max_s;

endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side scoreboard: tracks pending writes per register and stalls ID on
// read-after-write hazards or pending-counter overflow. No forwarding path.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_REGS = SB_NUM_REGS,
    parameter int CNT_W    = SB_CNT_W
)
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [REG_ADDR_W-1:0] issue_rs1,
    input  logic [REG_ADDR_W-1:0] issue_rs2,
    input  logic                  issue_use_rs1,
    input  logic                  issue_use_rs2,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  issue_we,
    output logic                  stall,
    input  logic                  wb_valid,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    input  logic                  flush,
    output logic [NUM_REGS-1:0]   busy_mask,
    output logic                  underflow_err
);

    issue_req_t           issue_s;
    logic [NUM_REGS-1:1]  rd_onehot_s;
    logic [NUM_REGS-1:1]  wb_onehot_s;
    logic [NUM_REGS-1:1]  at_max_s;
    logic [NUM_REGS-1:1]  inc_s;
    logic [NUM_REGS-1:1]  dec_s;
    logic [NUM_REGS-1:0]  nonzero_s;
    logic [CNT_W-1:0]     cnt_s [NUM_REGS];
    logic                 rs1_busy_s;
    logic                 rs2_busy_s;
    logic                 haz_s;
    logic                 ovf_s;
    logic                 stall_s;
    logic                 accept_s;
    logic                 underflow_s;
    logic                 underflow_err_r;

    assign issue_s = '{valid:   issue_valid,
                       rs1:     issue_rs1,
                       use_rs1: issue_use_rs1,
                       rs2:     issue_rs2,
                       use_rs2: issue_use_rs2,
                       rd:      issue_rd,
                       we:      issue_we};

    // Destination and writeback decoders; x0 has no decode bit at all.
    always_comb begin
        rd_onehot_s = {(NUM_REGS-1){1'b0}};
        wb_onehot_s = {(NUM_REGS-1){1'b0}};
        for (int i = 1; i < NUM_REGS; i++) begin
            rd_onehot_s[i] = (issue_s.rd == REG_ADDR_W'(i));
            wb_onehot_s[i] = (wb_rd == REG_ADDR_W'(i));
        end
    end

    // Hazard, overflow and stall decisions from registered counter state only.
    always_comb begin
        rs1_busy_s  = issue_s.use_rs1 && nonzero_s[issue_s.rs1];
        rs2_busy_s  = issue_s.use_rs2 && nonzero_s[issue_s.rs2];
        haz_s       = issue_s.valid && (rs1_busy_s || rs2_busy_s);
        ovf_s       = issue_s.valid && issue_s.we && (issue_s.rd != {REG_ADDR_W{1'b0}}) &&
                      (cnt_s[issue_s.rd] == {CNT_W{1'b1}});
        stall_s     = reset || haz_s || ovf_s;
        accept_s    = issue_s.valid && !stall_s;
        underflow_s = wb_valid && |(wb_onehot_s & ~nonzero_s[NUM_REGS-1:1]);
    end

    assign cnt_s[0]     = {CNT_W{1'b0}};
    assign nonzero_s[0] = 1'b0;

    for (genvar g = 1; g < NUM_REGS; g++) begin : g_cnt
        assign inc_s[g] = accept_s && issue_s.we && rd_onehot_s[g] && !at_max_s[g];
        assign dec_s[g] = wb_valid && wb_onehot_s[g] && nonzero_s[g];

        sb_counter #(
            .CNT_W   (CNT_W)
        ) u_cnt (
            .clk     (clk),
            .reset   (reset),
            .clr     (flush),
            .inc     (inc_s[g]),
            .dec     (dec_s[g]),
            .count   (cnt_s[g]),
            .nonzero (nonzero_s[g]),
            .at_max  (at_max_s[g])
        );
    end

    // Sticky error for writebacks that have no matching pending write.
    always_ff @(posedge clk) begin
        if (reset) begin
            underflow_err_r <= 1'b0;
        end else if (underflow_s) begin
            underflow_err_r <= 1'b1;
        end else begin
            underflow_err_r <= underflow_err_r;
        end
    end

    assign stall         = stall_s;
    assign busy_mask     = nonzero_s;
    assign underflow_err = underflow_err_r;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench: directed vector table followed by random traffic
// checked against a per-register pending-count model.
module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [4:0]  issue_rs1;
    logic [4:0]  issue_rs2;
    logic        issue_use_rs1;
    logic        issue_use_rs2;
    logic [4:0]  issue_rd;
    logic        issue_we;
    logic        stall;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        flush;
    logic [31:0] busy_mask;
    logic        underflow_err;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk           (clk),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_rs1     (issue_rs1),
        .issue_rs2     (issue_rs2),
        .issue_use_rs1 (issue_use_rs1),
        .issue_use_rs2 (issue_use_rs2),
        .issue_rd      (issue_rd),
        .issue_we      (issue_we),
        .stall         (stall),
        .wb_valid      (wb_valid),
        .wb_rd         (wb_rd),
        .flush         (flush),
        .busy_mask     (busy_mask),
        .underflow_err (underflow_err)
    );

    typedef struct {
        logic        rst;
        logic        iv;
        logic [4:0]  rs1;
        logic        u1;
        logic [4:0]  rs2;
        logic        u2;
        logic [4:0]  rd;
        logic        we;
        logic        wbv;
        logic [4:0]  wbrd;
        logic        fl;
        logic        est;
        logic [31:0] ebm;
        logic        eue;
    } vec_t;

    localparam int MAXC = 3;

    vec_t tbl[$];
    int   n_cmp = 0;
    int   n_bad = 0;
    int   mcnt[32];
    bit   muerr;

    function automatic vec_t v(input logic rst, input logic iv, input logic [4:0] rs1,
                               input logic u1, input logic [4:0] rs2, input logic u2,
                               input logic [4:0] rd, input logic we, input logic wbv,
                               input logic [4:0] wbrd, input logic fl, input logic est,
                               input logic [31:0] ebm, input logic eue);
        vec_t r;
        r.rst = rst; r.iv = iv; r.rs1 = rs1; r.u1 = u1; r.rs2 = rs2; r.u2 = u2;
        r.rd = rd; r.we = we; r.wbv = wbv; r.wbrd = wbrd; r.fl = fl;
        r.est = est; r.ebm = ebm; r.eue = eue;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t r);
        reset = r.rst; issue_valid = r.iv; issue_rs1 = r.rs1; issue_use_rs1 = r.u1;
        issue_rs2 = r.rs2; issue_use_rs2 = r.u2; issue_rd = r.rd; issue_we = r.we;
        wb_valid = r.wbv; wb_rd = r.wbrd; flush = r.fl;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) mcnt[i] = 0;
    endtask

    // Expected combinational outputs from the pending counts and current inputs.
    task automatic model_outputs(output bit st, output logic [31:0] bm);
        bit haz;
        bit ovf;
        bm = 32'h0;
        for (int i = 1; i < 32; i++) bm[i] = (mcnt[i] != 0);
        haz = issue_valid && ((issue_use_rs1 && mcnt[issue_rs1] != 0) ||
                              (issue_use_rs2 && mcnt[issue_rs2] != 0));
        ovf = issue_valid && issue_we && issue_rd != 5'd0 && mcnt[issue_rd] == MAXC;
        st  = reset || haz || ovf;
    endtask

    task automatic model_edge();
        bit          st;
        logic [31:0] bm;
        int          pre_wb;
        model_outputs(st, bm);
        pre_wb = mcnt[wb_rd];
        if (reset) begin
            model_clear();
            muerr = 1'b0;
        end else begin
            if (wb_valid && wb_rd != 5'd0 && pre_wb == 0) muerr = 1'b1;
            if (flush) begin
                model_clear();
            end else begin
                if (issue_valid && !st && issue_we && issue_rd != 5'd0) mcnt[issue_rd]++;
                if (wb_valid && wb_rd != 5'd0 && pre_wb != 0) mcnt[wb_rd]--;
            end
        end
    endtask

    initial begin
        bit          st;
        logic [31:0] bm;

        apply(v(1,0,0,0,0,0,0,0,0,0,0, 0,32'h0,0));
        model_clear();
        muerr = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);

        //      rst iv rs1 u1 rs2 u2 rd we wbv wbrd fl  stall busy      uerr
        tbl.push_back(v(1,0, 0,0, 0,0, 0,0,0, 0,0, 1,32'h0,    0));
        tbl.push_back(v(0,0, 0,0, 0,0, 0,0,0, 0,0, 0,32'h0,    0));
        tbl.push_back(v(0,1, 0,0, 0,0, 5,1,0, 0,0, 0,32'h0,    0));
        tbl.push_back(v(0,1, 5,1, 0,0, 0,0,0, 0,0, 1,32'h20,   0));
        tbl.push_back(v(0,1, 5,1, 0,0, 0,0,1, 5,0, 1,32'h20,   0));
        tbl.push_back(v(0,1, 5,1, 0,0, 0,0,0, 0,0, 0,32'h0,    0));
        tbl.push_back(v(0,1, 0,0, 0,0, 7,1,0, 0,0, 0,32'h0,    0));
        tbl.push_back(v(0,1, 0,0, 0,0, 7,1,1, 7,0, 0,32'h80,   0));
        tbl.push_back(v(0,0, 0,0, 0,0, 0,0,0, 0,0, 0,32'h80,   0));
        tbl.push_back(v(0,0, 0,0, 0,0, 0,0,1, 7,0, 0,32'h80,   0));
        tbl.push_back(v(0,0, 0,0, 0,0, 0,0,0, 0,0, 0,32'h0,    0));
        tbl.push_back(v(0,1, 0,0, 0,0, 9,1,0, 0,0, 0,32'h0,    0));
        tbl.push_back(v(0,1, 0,0, 0,0, 9,1,0, 0,0, 0,32'h200,  0));
        tbl.push_back(v(0,1, 0,0, 0,0, 9,1,0, 0,0, 0,32'h200,  0));
        tbl.push_back(v(0,1, 0,0, 0,0, 9,1,0, 0,0, 1,32'h200,  0));
        tbl.push_back(v(0,1, 0,0, 0,0, 9,1,1, 9,0, 1,32'h200,  0));
        tbl.push_back(v(0,1, 0,0, 0,0, 9,1,0, 0,0, 0,32'h200,  0));
        tbl.push_back(v(0,0, 0,0, 0,0, 0,0,1, 9,0, 0,32'h200,  0));
        tbl.push_back(v(0,0, 0,0, 0,0, 0,0,1, 9,0, 0,32'h200,  0));
        tbl.push_back(v(0,0, 0,0, 0,0, 0,0,1, 9,0, 0,32'h200,  0));
        tbl.push_back(v(0,0, 0,0, 0,0, 0,0,0, 0,0, 0,32'h0,    0));
        tbl.push_back(v(0,1, 0,0, 0,0, 0,1,0, 0,0, 0,32'h0,    0));
        tbl.push_back(v(0,1, 0,1, 0,1, 0,0,0, 0,0, 0,32'h0,    0));
        tbl.push_back(v(0,0, 0,0, 0,0, 0,0,1, 0,0, 0,32'h0,    0));
        tbl.push_back(v(0,0, 0,0, 0,0, 0,0,0, 0,0, 0,32'h0,    0));
        tbl.push_back(v(0,1, 0,0, 0,0, 3,1,0, 0,0, 0,32'h0,    0));
        tbl.push_back(v(0,1, 0,0, 0,0, 4,1,0, 0,0, 0,32'h8,    0));
        tbl.push_back(v(0,0, 0,0, 0,0, 0,0,0, 0,1, 0,32'h18,   0));
        tbl.push_back(v(0,0, 0,0, 0,0, 0,0,1, 3,0, 0,32'h0,    0));
        tbl.push_back(v(0,0, 0,0, 0,0, 0,0,0, 0,0, 0,32'h0,    1));
        tbl.push_back(v(1,0, 0,0, 0,0, 0,0,0, 0,0, 1,32'h0,    1));
        tbl.push_back(v(0,0, 0,0, 0,0, 0,0,0, 0,0, 0,32'h0,    0));
        tbl.push_back(v(0,1, 0,0, 0,0, 6,1,0, 0,1, 0,32'h0,    0));
        tbl.push_back(v(0,0, 0,0, 0,0, 0,0,0, 0,0, 0,32'h0,    0));
        tbl.push_back(v(0,1, 0,0, 0,0, 6,1,0, 0,0, 0,32'h0,    0));
        tbl.push_back(v(1,1, 0,0, 0,0, 6,1,0, 0,0, 1,32'h40,   0));
        tbl.push_back(v(0,0, 0,0, 0,0, 0,0,0, 0,0, 0,32'h0,    0));
        tbl.push_back(v(0,1, 0,0, 0,0,10,1,0, 0,0, 0,32'h0,    0));
        tbl.push_back(v(0,1, 0,0,10,1, 0,0,0, 0,0, 1,32'h400,  0));
        tbl.push_back(v(0,1, 0,0,10,0, 0,0,0, 0,0, 0,32'h400,  0));
        tbl.push_back(v(0,0, 0,0, 0,0, 0,0,1,10,0, 0,32'h400,  0));
        tbl.push_back(v(0,0, 0,0, 0,0, 0,0,0, 0,0, 0,32'h0,    0));
        tbl.push_back(v(0,1, 0,0, 0,0,11,1,0, 0,0, 0,32'h0,    0));
        tbl.push_back(v(0,0,11,1, 0,0, 0,0,0, 0,0, 0,32'h800,  0));
        tbl.push_back(v(0,0, 0,0, 0,0, 0,0,1,11,0, 0,32'h800,  0));
        tbl.push_back(v(0,0, 0,0, 0,0, 0,0,0, 0,0, 0,32'h0,    0));

        for (int k = 0; k < tbl.size(); k++) begin
            apply(tbl[k]);
            #1;
            check($sformatf("row%0d stall", k), {31'b0, stall}, {31'b0, tbl[k].est});
            check($sformatf("row%0d busy_mask", k), busy_mask, tbl[k].ebm);
            check($sformatf("row%0d underflow_err", k), {31'b0, underflow_err}, {31'b0, tbl[k].eue});
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end

        for (int n = 0; n < 1500; n++) begin
            reset         = ($urandom_range(0, 99) == 0);
            flush         = ($urandom_range(0, 39) == 0);
            issue_valid   = ($urandom_range(0, 3) != 0);
            issue_rs1     = 5'($urandom_range(0, 7));
            issue_rs2     = 5'($urandom_range(0, 7));
            issue_use_rs1 = 1'($urandom_range(0, 1));
            issue_use_rs2 = 1'($urandom_range(0, 1));
            issue_rd      = 5'($urandom_range(0, 7));
            issue_we      = ($urandom_range(0, 9) < 7);
            wb_valid      = ($urandom_range(0, 9) < 4);
            wb_rd         = 5'($urandom_range(0, 7));
            #1;
            model_outputs(st, bm);
            check($sformatf("rnd%0d stall", n), {31'b0, stall}, {31'b0, st});
            check($sformatf("rnd%0d busy_mask", n), busy_mask, bm);
            check($sformatf("rnd%0d underflow_err", n), {31'b0, underflow_err}, {31'b0, muerr});
            @(posedge clk);
            model_edge();
            @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
